// File: rtl/uart_tx_arb_pkg.sv
// Shared types and defaults for the mpss UART TX packet arbiter.
// Build option: define UART_TX_ARB_TIMEOUT_EN to enable the stalled-lock timeout.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARB    = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam int BYTE_W                 = 8;
  localparam int NUM_REQ_DEFAULT        = 4;
  localparam int TIMEOUT_CYCLES_DEFAULT = 1024;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// rr_pick: combinational rotating-priority selector, searching upward from ptr_i+1.
// Reusable by other mpss arbiters; returns a one-hot grant and a valid flag.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // The first hit in rotation order wins; the previous winner (ptr_i) is checked last.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IDX_W'((int'(ptr_i) + i) % N);
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin, packet-locking arbiter sharing one UART TX between NUM_REQ sources.
// Build option: UART_TX_ARB_TIMEOUT_EN adds a stall counter that forcibly drops a stuck lock.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ        = NUM_REQ_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*BYTE_W-1:0] data_i,
  input  logic [NUM_REQ-1:0]        last_i,
  output logic [NUM_REQ-1:0]        ack_o,
  output logic                      tx_req_o,
  output logic [BYTE_W-1:0]         tx_data_o,
  input  logic                      tx_ack_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      busy_o,
  output logic                      timeout_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_cfg_check
    $error("uart_tx_arb: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 2");
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;

  logic [NUM_REQ-1:0] pickGrant;
  logic               pickValid;
  logic [IDX_W-1:0]   pickIdx;
  logic               ownerReq;
  logic               ownerLast;
  logic [BYTE_W-1:0]  ownerData;
  logic               xfer;
  logic               timeoutHit;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .grant_o (pickGrant),
    .valid_o (pickValid)
  );

  // Owner mux is driven by the registered grant, so the locked path stays purely combinational.
  always_comb begin
    ownerReq  = 1'b0;
    ownerLast = 1'b0;
    ownerData = '0;
    pickIdx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) begin
        ownerReq  = req_i[k];
        ownerLast = last_i[k];
        ownerData = data_i[k*BYTE_W +: BYTE_W];
      end
      if (pickGrant[k]) pickIdx = IDX_W'(k);
    end
  end

  assign busy_o    = (state_q == LOCKED);
  assign grant_o   = grant_q;
  assign tx_req_o  = busy_o & ownerReq;
  assign tx_data_o = busy_o ? ownerData : '0;
  assign xfer      = tx_req_o & tx_ack_i;
  assign ack_o     = (busy_o & tx_ack_i) ? (grant_q & req_i) : '0;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(TIMEOUT_CYCLES - 2);

  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic             timeout_q;

  // Fires on the edge where the stall count would reach TIMEOUT_CYCLES-1.
  assign timeoutHit = busy_o & ~xfer & (stallCnt_q == CNT_FIRE);

  always_comb begin
    stallCnt_d = stallCnt_q + 1'b1;
    if (!busy_o || xfer || timeoutHit) stallCnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stallCnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      stallCnt_q <= stallCnt_d;
      timeout_q  <= timeoutHit;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeoutHit = 1'b0;
  assign timeout_o  = 1'b0;
`endif

  // Leaving LOCKED always records the owner in ptr so it gets lowest priority next round.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (|req_i) state_d = ARB;
      end
      ARB: begin
        if (pickValid) begin
          state_d = LOCKED;
          grant_d = pickGrant;
          owner_d = pickIdx;
        end else begin
          state_d = IDLE;
        end
      end
      LOCKED: begin
        if ((xfer && ownerLast) || timeoutHit) begin
          state_d = IDLE;
          ptr_d   = owner_q;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      owner_q <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
    end
  end

endmodule
